bitnet_sequencer: RTL and testbench

//  Next-generation BitNet control unit: fetches 8-bit instructions, sequences data/weight/stack transfers

---
 rtl/bitnet_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_bitnet_sequencer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitnet_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bitnet_sequencer
//  Purpose  : BitNet control unit. Fetches 8-bit instructions, sequences
//             data/weight/stack transfers over handshakes, and drives an
//             external variable-latency NN compute unit. Supports run control,
//             signed pointer strides, DJNZ hardware loops and an illegal flag.
//  Revision : 1.0  initial release
// ============================================================================
module bitnet_sequencer #(
    parameter int PROGRAM_LENGTH = 256,
    parameter int DATA_LENGTH    = 256,
    parameter int WEIGHT_LENGTH  = 256,
    parameter int X_SIZE         = 1024,
    parameter int W_SIZE         = 1024,
    parameter int TRIT_SIZE      = 4,
    parameter int LOOP_W         = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               start_in,
    output logic                               busy_out,
    output logic                               halted_out,
    output logic                               illegal_out,
    output logic [$clog2(PROGRAM_LENGTH)-1:0]  instr_addr_out,
    output logic                               instr_req_out,
    input  logic [7:0]                         instr_in,
    input  logic                               instr_valid_in,
    output logic [$clog2(DATA_LENGTH)-1:0]     data_addr_out,
    output logic                               data_req_out,
    input  logic [X_SIZE-1:0]                  data_x_in,
    input  logic [X_SIZE-1:0]                  data_y_in,
    input  logic                               data_valid_in,
    output logic [$clog2(WEIGHT_LENGTH)-1:0]   weight_addr_out,
    output logic                               weight_rd_out,
    output logic                               weight_wr_out,
    output logic [W_SIZE-1:0]                  weight_out,
    input  logic [W_SIZE-1:0]                  weight_in,
    input  logic                               weight_done_in,
    output logic [X_SIZE-1:0]                  stack_out,
    output logic                               stack_push_out,
    input  logic                               stack_out_ready,
    input  logic [X_SIZE-1:0]                  stack_in,
    output logic                               stack_pop_out,
    input  logic                               stack_in_valid,
    output logic [X_SIZE-1:0]                  x_out,
    output logic [X_SIZE-1:0]                  y_out,
    output logic [W_SIZE-1:0]                  w_out,
    output logic [W_SIZE-1:0]                  grad_out,
    output logic [TRIT_SIZE-1:0]               trit_out,
    output logic [1:0]                         nn_op_out,
    output logic                               nn_start_out,
    input  logic                               nn_done_in,
    input  logic [X_SIZE-1:0]                  nn_x_in,
    input  logic [X_SIZE-1:0]                  nn_y_in,
    input  logic [W_SIZE-1:0]                  nn_grad_in,
    output logic [X_SIZE-1:0]                  inference_out,
    output logic                               inference_valid
);

    localparam int IPW = $clog2(PROGRAM_LENGTH);
    localparam int DW  = $clog2(DATA_LENGTH);
    localparam int AW  = $clog2(WEIGHT_LENGTH);

    localparam logic [3:0] OP_TRIT    = 4'h0;
    localparam logic [3:0] OP_DADD    = 4'h1;
    localparam logic [3:0] OP_AADD    = 4'h2;
    localparam logic [3:0] OP_LOADD   = 4'h3;
    localparam logic [3:0] OP_LOADW   = 4'h4;
    localparam logic [3:0] OP_STOREW  = 4'h5;
    localparam logic [3:0] OP_ALU     = 4'h6;
    localparam logic [3:0] OP_PUSH    = 4'h7;
    localparam logic [3:0] OP_POP     = 4'h8;
    localparam logic [3:0] OP_NN      = 4'h9;
    localparam logic [3:0] OP_LOOPSET = 4'hA;
    localparam logic [3:0] OP_DJNZ    = 4'hB;
    localparam logic [3:0] OP_EMIT    = 4'hC;
    localparam logic [3:0] OP_HALT    = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IPW-1:0]         ip_q;
    logic [DW-1:0]          d_q;
    logic [AW-1:0]          a_q;
    logic [LOOP_W-1:0]      lc_q;
    logic [X_SIZE-1:0]      x_q, y_q, stack_out_q, inference_q;
    logic [W_SIZE-1:0]      w_q, grad_q, weight_out_q;
    logic [TRIT_SIZE-1:0]   trit_q;
    logic [7:0]             instr_q;
    logic [1:0]             nn_op_q;
    logic                   busy_q, halted_q, illegal_q, instr_req_q, data_req_q;
    logic                   weight_rd_q, weight_wr_q, push_q, pop_q, nn_start_q, inference_valid_q;

    logic [3:0]             op;
    logic [3:0]             imm;
    logic signed [3:0]      s4;
    logic [LOOP_W-1:0]      lc_shift;
    logic [LOOP_W-1:0]      lc_dec;
    logic                   wait_done;

    assign op     = instr_q[7:4];
    assign imm    = instr_q[3:0];
    assign s4     = instr_q[3:0];
    assign lc_dec = lc_q - LOOP_W'(1);

    // LOOPSET shifts a nibble into the loop counter; a 4-bit counter is simply replaced
    generate
        if (LOOP_W == 4) begin : g_lc_narrow
            assign lc_shift = imm;
        end else begin : g_lc_wide
            assign lc_shift = {lc_q[LOOP_W-5:0], imm};
        end
    endgenerate

    // Completion of the outstanding transaction; strobe-cycle done pulses are ignored
    always_comb begin
        wait_done = 1'b0;
        case (op)
            OP_LOADD:            wait_done = data_req_q && data_valid_in;
            OP_LOADW, OP_STOREW: wait_done = weight_done_in && !weight_rd_q && !weight_wr_q;
            OP_PUSH:             wait_done = push_q && stack_out_ready;
            OP_POP:              wait_done = pop_q && stack_in_valid;
            OP_NN:               wait_done = nn_done_in && !nn_start_q;
            default:             wait_done = 1'b0;
        endcase
    end

    // Sequencer FSM with all architectural registers and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q           <= S_IDLE;
            ip_q              <= '0;
            d_q               <= '0;
            a_q               <= '0;
            lc_q              <= '0;
            x_q               <= '0;
            y_q               <= '0;
            w_q               <= '0;
            grad_q            <= '0;
            trit_q            <= '0;
            instr_q           <= '0;
            nn_op_q           <= '0;
            stack_out_q       <= '0;
            weight_out_q      <= '0;
            inference_q       <= '0;
            busy_q            <= 1'b0;
            halted_q          <= 1'b0;
            illegal_q         <= 1'b0;
            instr_req_q       <= 1'b0;
            data_req_q        <= 1'b0;
            weight_rd_q       <= 1'b0;
            weight_wr_q       <= 1'b0;
            push_q            <= 1'b0;
            pop_q             <= 1'b0;
            nn_start_q        <= 1'b0;
            inference_valid_q <= 1'b0;
        end else begin
            // single-cycle strobes
            weight_rd_q       <= 1'b0;
            weight_wr_q       <= 1'b0;
            nn_start_q        <= 1'b0;
            inference_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_q     <= S_FETCH;
                        ip_q        <= '0;
                        halted_q    <= 1'b0;
                        illegal_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        instr_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (instr_valid_in) begin
                        instr_q     <= instr_in;
                        instr_req_q <= 1'b0;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // default: single-cycle op retires and the next fetch starts
                    state_q     <= S_FETCH;
                    instr_req_q <= 1'b1;
                    ip_q        <= ip_q + IPW'(1);
                    case (op)
                        OP_TRIT: trit_q <= TRIT_SIZE'(imm);
                        OP_DADD: d_q <= d_q + DW'(s4);
                        OP_AADD: a_q <= a_q + AW'(s4);
                        OP_LOADD: begin
                            if (imm[1:0] != 2'b00) begin
                                data_req_q  <= 1'b1;
                                state_q     <= S_WAIT;
                                instr_req_q <= 1'b0;
                                ip_q        <= ip_q;
                            end
                        end
                        OP_LOADW, OP_STOREW: begin
                            weight_rd_q  <= (op == OP_LOADW);
                            weight_wr_q  <= (op == OP_STOREW);
                            weight_out_q <= w_q;
                            state_q      <= S_WAIT;
                            instr_req_q  <= 1'b0;
                            ip_q         <= ip_q;
                        end
                        OP_ALU: begin
                            case (imm)
                                4'd0: begin x_q <= y_q; y_q <= x_q; end
                                4'd1: x_q <= y_q;
                                4'd2: y_q <= x_q;
                                4'd3: x_q <= x_q ^ y_q;
                                4'd4: y_q <= y_q ^ x_q;
                                4'd5: x_q <= x_q & y_q;
                                4'd6: y_q <= y_q & x_q;
                                4'd7: x_q <= x_q | y_q;
                                4'd8: y_q <= y_q | x_q;
                                default: ;
                            endcase
                        end
                        OP_PUSH: begin
                            stack_out_q <= imm[0] ? y_q : x_q;
                            push_q      <= 1'b1;
                            state_q     <= S_WAIT;
                            instr_req_q <= 1'b0;
                            ip_q        <= ip_q;
                        end
                        OP_POP: begin
                            pop_q       <= 1'b1;
                            state_q     <= S_WAIT;
                            instr_req_q <= 1'b0;
                            ip_q        <= ip_q;
                        end
                        OP_NN: begin
                            nn_op_q     <= imm[1:0];
                            nn_start_q  <= 1'b1;
                            state_q     <= S_WAIT;
                            instr_req_q <= 1'b0;
                            ip_q        <= ip_q;
                        end
                        OP_LOOPSET: lc_q <= lc_shift;
                        OP_DJNZ: begin
                            if (lc_q != '0) begin
                                lc_q <= lc_dec;
                                if (lc_dec != '0) begin
                                    ip_q <= ip_q - IPW'(imm);
                                end
                            end
                        end
                        OP_EMIT: begin
                            inference_q       <= y_q;
                            inference_valid_q <= 1'b1;
                        end
                        OP_HALT: begin
                            state_q     <= S_IDLE;
                            instr_req_q <= 1'b0;
                            ip_q        <= ip_q;
                            halted_q    <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                        default: illegal_q <= 1'b1;
                    endcase
                end
                S_WAIT: begin
                    if (wait_done) begin
                        case (op)
                            OP_LOADD: begin
                                if (imm[0]) x_q <= data_x_in;
                                if (imm[1]) y_q <= data_y_in;
                                data_req_q <= 1'b0;
                            end
                            OP_LOADW: w_q <= weight_in;
                            OP_PUSH:  push_q <= 1'b0;
                            OP_POP: begin
                                if (imm[0]) y_q <= stack_in;
                                else        x_q <= stack_in;
                                pop_q <= 1'b0;
                            end
                            OP_NN: begin
                                case (nn_op_q)
                                    2'd0: y_q <= nn_y_in;
                                    2'd1: begin x_q <= nn_x_in; grad_q <= nn_grad_in; end
                                    2'd2: w_q <= w_q ^ nn_grad_in;
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                        state_q     <= S_FETCH;
                        instr_req_q <= 1'b1;
                        ip_q        <= ip_q + IPW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_out        = busy_q;
    assign halted_out      = halted_q;
    assign illegal_out     = illegal_q;
    assign instr_addr_out  = ip_q;
    assign instr_req_out   = instr_req_q;
    assign data_addr_out   = d_q;
    assign data_req_out    = data_req_q;
    assign weight_addr_out = a_q;
    assign weight_rd_out   = weight_rd_q;
    assign weight_wr_out   = weight_wr_q;
    assign weight_out      = weight_out_q;
    assign stack_out       = stack_out_q;
    assign stack_push_out  = push_q;
    assign stack_pop_out   = pop_q;
    assign x_out           = x_q;
    assign y_out           = y_q;
    assign w_out           = w_q;
    assign grad_out        = grad_q;
    assign trit_out        = trit_q;
    assign nn_op_out       = nn_op_q;
    assign nn_start_out    = nn_start_q;
    assign inference_out   = inference_q;
    assign inference_valid = inference_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bitnet_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bitnet_sequencer
//  Purpose  : Self-checking bench for bitnet_sequencer. An instruction-level
//             reference model predicts EMIT values and final register state;
//             randomized-latency responders serve the external interfaces.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitnet_sequencer;

    localparam int XS = 64;
    localparam int WS = 64;

    logic clk_in = 1'b0;
    logic rst_in, start_in;
    logic busy_out, halted_out, illegal_out;
    logic [7:0] instr_addr_out, data_addr_out, weight_addr_out;
    logic instr_req_out, instr_valid_in, data_req_out, data_valid_in;
    logic [7:0] instr_in;
    logic [XS-1:0] data_x_in, data_y_in, stack_out, stack_in, x_out, y_out, nn_x_in, nn_y_in, inference_out;
    logic [WS-1:0] weight_out, weight_in, w_out, grad_out, nn_grad_in;
    logic weight_rd_out, weight_wr_out, weight_done_in;
    logic stack_push_out, stack_out_ready, stack_pop_out, stack_in_valid;
    logic [3:0] trit_out;
    logic [1:0] nn_op_out;
    logic nn_start_out, nn_done_in, inference_valid;

    bitnet_sequencer #(.X_SIZE(XS), .W_SIZE(WS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .busy_out(busy_out), .halted_out(halted_out), .illegal_out(illegal_out),
        .instr_addr_out(instr_addr_out), .instr_req_out(instr_req_out),
        .instr_in(instr_in), .instr_valid_in(instr_valid_in),
        .data_addr_out(data_addr_out), .data_req_out(data_req_out),
        .data_x_in(data_x_in), .data_y_in(data_y_in), .data_valid_in(data_valid_in),
        .weight_addr_out(weight_addr_out), .weight_rd_out(weight_rd_out), .weight_wr_out(weight_wr_out),
        .weight_out(weight_out), .weight_in(weight_in), .weight_done_in(weight_done_in),
        .stack_out(stack_out), .stack_push_out(stack_push_out), .stack_out_ready(stack_out_ready),
        .stack_in(stack_in), .stack_pop_out(stack_pop_out), .stack_in_valid(stack_in_valid),
        .x_out(x_out), .y_out(y_out), .w_out(w_out), .grad_out(grad_out), .trit_out(trit_out),
        .nn_op_out(nn_op_out), .nn_start_out(nn_start_out), .nn_done_in(nn_done_in),
        .nn_x_in(nn_x_in), .nn_y_in(nn_y_in), .nn_grad_in(nn_grad_in),
        .inference_out(inference_out), .inference_valid(inference_valid)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [7:0]  prog [256];
    logic [63:0] wmem [256];
    logic [63:0] stk [$];
    logic [63:0] expq [$];
    int ncall = 0, npush = 0, npop = 0;
    int n_dreq = 0, n_wrd = 0, n_wwr = 0, n_inf = 0, fetch2 = 0;
    bit fast = 1'b0;
    int dlat = 0, wlat = 0, nlat = 0;

    // reference model state
    logic [7:0]  m_ip, m_d, m_a, m_lc;
    logic [3:0]  m_trit;
    logic [63:0] m_x, m_y, m_w, m_g;
    logic [63:0] m_wmem [256];
    logic [63:0] m_stack [$];
    bit          m_ill;
    int          m_ncall = 0, m_npush = 0, m_npop = 0;

    function automatic logic [63:0] hx(input logic [7:0] a);
        return {32'hA5A5A5A5 ^ {24'h0, a}, {24'h0, a} * 32'h9E3779B1};
    endfunction
    function automatic logic [63:0] hy(input logic [7:0] a);
        return {32'h3C3C3C3C ^ {a, 24'h0}, ({24'h0, a} * 32'h85EBCA6B) ^ 32'h1234};
    endfunction
    function automatic logic [63:0] hw(input int a);
        return {32'(a) * 32'h27D4EB2F, 32'hC0DE0000 | 32'(a)};
    endfunction
    function automatic logic [63:0] nnx(input int k);
        return {32'(k) * 32'h01000193, 32'hDEAD0000 + 32'(k)};
    endfunction
    function automatic logic [63:0] nny(input int k);
        return {32'hBEEF0000 ^ 32'(k), 32'(k) * 32'h7FEB352D};
    endfunction
    function automatic logic [63:0] nng(input int k);
        return {32'(k) * 32'h846CA68B, 32'h600D0000 | 32'(k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // instruction-level interpretation of the program; EMIT values go to the scoreboard
    task automatic model_run();
        logic [7:0] ins, nxt;
        logic [3:0] op, imm;
        logic [63:0] t;
        int s, k;
        bit done = 1'b0;
        m_ip = 8'd0;
        m_ill = 1'b0;
        for (int steps = 0; steps < 20000 && !done; steps++) begin
            ins = prog[m_ip];
            op  = ins[7:4];
            imm = ins[3:0];
            s   = (imm >= 4'd8) ? int'(imm) - 16 : int'(imm);
            nxt = m_ip + 8'd1;
            case (op)
                4'h0: m_trit = imm;
                4'h1: m_d = 8'((int'(m_d) + s) & 255);
                4'h2: m_a = 8'((int'(m_a) + s) & 255);
                4'h3: begin
                    if (imm[0]) m_x = hx(m_d);
                    if (imm[1]) m_y = hy(m_d);
                end
                4'h4: m_w = m_wmem[m_a];
                4'h5: m_wmem[m_a] = m_w;
                4'h6: case (imm)
                    4'd0: begin t = m_x; m_x = m_y; m_y = t; end
                    4'd1: m_x = m_y;
                    4'd2: m_y = m_x;
                    4'd3: m_x = m_x ^ m_y;
                    4'd4: m_y = m_y ^ m_x;
                    4'd5: m_x = m_x & m_y;
                    4'd6: m_y = m_y & m_x;
                    4'd7: m_x = m_x | m_y;
                    4'd8: m_y = m_y | m_x;
                    default: ;
                endcase
                4'h7: begin m_stack.push_back(imm[0] ? m_y : m_x); m_npush++; end
                4'h8: begin
                    t = m_stack.pop_back();
                    m_npop++;
                    if (imm[0]) m_y = t; else m_x = t;
                end
                4'h9: begin
                    k = m_ncall;
                    m_ncall++;
                    case (imm[1:0])
                        2'd0: m_y = nny(k);
                        2'd1: begin m_x = nnx(k); m_g = nng(k); end
                        2'd2: m_w = m_w ^ nng(k);
                        default: ;
                    endcase
                end
                4'hA: m_lc = {m_lc[3:0], imm};
                4'hB: if (m_lc != 8'd0) begin
                    m_lc = m_lc - 8'd1;
                    if (m_lc != 8'd0) nxt = m_ip - {4'd0, imm};
                end
                4'hC: expq.push_back(m_y);
                4'hD: done = 1'b1;
                default: m_ill = 1'b1;
            endcase
            if (!done) m_ip = nxt;
        end
    endtask

    // instruction ROM responder
    initial begin
        instr_valid_in = 1'b0;
        instr_in = 8'd0;
        forever begin
            @(negedge clk_in);
            instr_valid_in = instr_req_out && (fast || ($urandom_range(0, 2) != 0));
            instr_in = instr_valid_in ? prog[instr_addr_out] : 8'($urandom);
            if (instr_valid_in && instr_addr_out == 8'd2) fetch2++;
        end
    end

    // data BRAM responder: valid after a latency counted from first request cycle
    initial begin
        int cnt = -1;
        data_valid_in = 1'b0;
        data_x_in = '0;
        data_y_in = '0;
        forever begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
            if (!data_req_out) cnt = -1;
            else begin
                if (cnt < 0) cnt = (dlat > 0) ? dlat : $urandom_range(0, 4);
                if (cnt == 0) begin
                    data_valid_in = 1'b1;
                    data_x_in = hx(data_addr_out);
                    data_y_in = hy(data_addr_out);
                end
                cnt--;
            end
        end
    end

    // weight BRAM responder, with a spurious done during the strobe cycle
    initial begin
        int cnt = 0;
        weight_done_in = 1'b0;
        weight_in = '0;
        forever begin
            @(negedge clk_in);
            weight_done_in = 1'b0;
            if (weight_rd_out || weight_wr_out) begin
                if (weight_wr_out) wmem[weight_addr_out] = weight_out;
                cnt = (wlat > 0) ? wlat : $urandom_range(1, 5);
                weight_done_in = ($urandom_range(0, 1) == 1);
                weight_in = {$urandom, $urandom};
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    weight_done_in = 1'b1;
                    weight_in = wmem[weight_addr_out];
                end
            end
        end
    end

    // NN unit responder, with a spurious done during the start cycle
    initial begin
        int cnt = 0;
        nn_done_in = 1'b0;
        nn_x_in = '0;
        nn_y_in = '0;
        nn_grad_in = '0;
        forever begin
            @(negedge clk_in);
            nn_done_in = 1'b0;
            if (nn_start_out) begin
                cnt = (nlat > 0) ? nlat : $urandom_range(1, 7);
                nn_done_in = ($urandom_range(0, 1) == 1);
                nn_x_in = {$urandom, $urandom};
                nn_y_in = {$urandom, $urandom};
                nn_grad_in = {$urandom, $urandom};
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    nn_done_in = 1'b1;
                    nn_x_in = nnx(ncall);
                    nn_y_in = nny(ncall);
                    nn_grad_in = nng(ncall);
                    ncall++;
                end
            end
        end
    end

    // stack responder with random back-pressure
    initial begin
        stack_out_ready = 1'b0;
        stack_in_valid = 1'b0;
        stack_in = '0;
        forever begin
            @(negedge clk_in);
            stack_out_ready = ($urandom_range(0, 2) == 0);
            if (stack_push_out && stack_out_ready) begin
                stk.push_back(stack_out);
                npush++;
            end
            stack_in_valid = 1'b0;
            if (stack_pop_out && stk.size() > 0 && $urandom_range(0, 2) == 0) begin
                stack_in = stk.pop_back();
                stack_in_valid = 1'b1;
                npop++;
            end
        end
    end

    // monitor: pops expected inference values and counts strobes
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_in);
            if (data_req_out) n_dreq++;
            if (weight_rd_out) n_wrd++;
            if (weight_wr_out) n_wwr++;
            if (inference_valid) begin
                n_inf++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL emit_unexpected: got %h, expected no output", inference_out);
                end else begin
                    e = expq.pop_front();
                    chk("emit", inference_out, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst_in = 1'b1;
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        m_ip = 0; m_d = 0; m_a = 0; m_lc = 0; m_trit = 0;
        m_x = 0; m_y = 0; m_w = 0; m_g = 0; m_ill = 1'b0;
        m_stack.delete();
        stk.delete();
        expq.delete();
        for (int i = 0; i < 256; i++) begin
            wmem[i] = hw(i);
            m_wmem[i] = hw(i);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({busy_out, halted_out, illegal_out, instr_req_out, data_req_out,
             weight_rd_out, weight_wr_out, stack_push_out, stack_pop_out, nn_start_out, inference_valid}), 64'd0);
        chk({tag, "_addr"}, 64'({instr_addr_out, data_addr_out, weight_addr_out, trit_out, nn_op_out}), 64'd0);
        chk({tag, "_data"}, x_out | y_out | w_out | grad_out | inference_out | stack_out | weight_out, 64'd0);
    endtask

    task automatic run_prog(input string tag, input int exact);
        int cnt = 0;
        int push0 = npush, pop0 = npop;
        m_npush = 0;
        m_npop = 0;
        model_run();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk({tag, "_start"}, {61'd0, busy_out, halted_out, illegal_out}, 64'd4);
        while (!halted_out && cnt < 5000) begin
            @(negedge clk_in);
            cnt++;
        end
        if (!halted_out) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: halted_out=0 after %0d cycles, expected 1", tag, cnt);
        end
        if (exact > 0) chk({tag, "_latency"}, 64'(cnt), 64'(exact));
        @(negedge clk_in);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
        chk({tag, "_trit"}, 64'(trit_out), 64'(m_trit));
        chk({tag, "_daddr"}, 64'(data_addr_out), 64'(m_d));
        chk({tag, "_waddr"}, 64'(weight_addr_out), 64'(m_a));
        chk({tag, "_x"}, x_out, m_x);
        chk({tag, "_y"}, y_out, m_y);
        chk({tag, "_w"}, w_out, m_w);
        chk({tag, "_grad"}, grad_out, m_g);
        chk({tag, "_illegal"}, 64'(illegal_out), 64'(m_ill));
        chk({tag, "_emit_left"}, 64'(expq.size()), 64'd0);
        chk({tag, "_pushes"}, 64'(npush - push0), 64'(m_npush));
        chk({tag, "_pops"}, 64'(npop - pop0), 64'(m_npop));
        expq.delete();
    endtask

    task automatic gen_prog();
        int n = $urandom_range(8, 30);
        int depth = m_stack.size();
        logic [3:0] op;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 11))
                0: op = 4'h0;  1: op = 4'h1;  2: op = 4'h2;  3: op = 4'h3;
                4: op = 4'h4;  5: op = 4'h5;  6: op = 4'h6;  7: op = 4'h7;
                8: op = 4'h8;  9: op = 4'h9;  10: op = 4'hC;
                default: op = ($urandom_range(0, 1) == 1) ? 4'hE : 4'hF;
            endcase
            if (op == 4'h8 && depth == 0) op = 4'h7;
            if (op == 4'h7) depth++;
            if (op == 4'h8) depth--;
            prog[i] = {op, 4'($urandom)};
        end
        prog[n] = 8'hD0;
    endtask

    initial begin
        int b0, b1, b2;
        rst_in = 1'b1;
        start_in = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'hD0;
        do_reset();
        @(negedge clk_in);
        check_zero("reset");

        // T1: TRIT=5, D+=-1, HALT with immediate fetch responses
        fast = 1'b1;
        prog[0] = 8'h05; prog[1] = 8'h1F; prog[2] = 8'hD0;
        run_prog("t1", 6);
        fast = 1'b0;

        // T2: LOADD X&Y with 3-cycle data latency
        dlat = 3;
        b0 = n_dreq;
        prog[0] = 8'h33; prog[1] = 8'hD0;
        run_prog("t2", 0);
        chk("t2_req_cycles", 64'(n_dreq - b0), 64'd4);
        dlat = 0;

        // T3: PUSH X then POP Y
        prog[0] = 8'h32; prog[1] = 8'h70; prog[2] = 8'h81; prog[3] = 8'hD0;
        run_prog("t3", 0);

        // T4: two-nibble LOOPSET, body, DJNZ back one, EMIT
        prog[0] = 8'hA0; prog[1] = 8'hA3; prog[2] = 8'h6F; prog[3] = 8'hB1; prog[4] = 8'hC0; prog[5] = 8'hD0;
        fetch2 = 0;
        b0 = n_inf;
        run_prog("t4", 0);
        chk("t4_body_count", 64'(fetch2), 64'd3);
        chk("t4_emit_count", 64'(n_inf - b0), 64'd1);

        // T6: illegal opcode is sticky until the next start
        prog[0] = 8'hF0; prog[1] = 8'hD0;
        run_prog("t6a", 0);
        prog[0] = 8'hD0;
        run_prog("t6b", 0);

        // randomized programs
        for (int p = 0; p < 10; p++) begin
            gen_prog();
            run_prog("rand", 0);
        end

        // T5: late LOADW, STOREW, NN interweave
        wlat = 5;
        nlat = 7;
        b0 = n_wrd; b1 = n_wwr; b2 = n_inf;
        prog[0] = 8'h21; prog[1] = 8'h40; prog[2] = 8'h21; prog[3] = 8'h50;
        prog[4] = 8'h90; prog[5] = 8'hC0; prog[6] = 8'hD0;
        run_prog("t5", 0);
        chk("t5_rd_pulses", 64'(n_wrd - b0), 64'd1);
        chk("t5_wr_pulses", 64'(n_wwr - b1), 64'd1);
        chk("t5_written", wmem[m_a], m_w);
        chk("t5_emit_count", 64'(n_inf - b2), 64'd1);

        // reset while waiting on the NN unit
        prog[0] = 8'h91; prog[1] = 8'hD0;
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("t5_nn_pending", 64'(busy_out), 64'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_zero("midreset");
        rst_in = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("midreset_idle", 64'({busy_out, instr_req_out, nn_start_out}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
